// File: rtl/csi_rgb_unpacker.sv
// Merged CSI-2 lane byte stream to RGB888 pixel unpacker with RGB888/RGB565 payloads.
// A residual buffer reassembles pixels that straddle beats; outputs are registered.
module csi_rgb_unpacker #(
    parameter  int LANES      = 4,
    localparam int OUT_PIXELS = (LANES >= 2) ? LANES / 2 : 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         mode,
    input  logic                         line_start,
    input  logic [LANES-1:0][7:0]        image_data,
    input  logic                         image_data_enable,
    output logic [OUT_PIXELS-1:0][23:0]  rgb,
    output logic [OUT_PIXELS-1:0]        rgb_enable,
    output logic                         residual_error
);

    // Byte window is padded so every constant pixel slice stays in range.
    localparam int NB = (LANES + 2 > 3 * OUT_PIXELS) ? LANES + 2 : 3 * OUT_PIXELS;
    localparam int CW = 5;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("csi_rgb_unpacker: LANES must be 1, 2, 4 or 8");
    end

    logic                         mode_r;
    logic [1:0]                   res_cnt_r;
    logic [1:0][7:0]              res_buf_r;
    logic [OUT_PIXELS-1:0][23:0]  rgb_r;
    logic [OUT_PIXELS-1:0]        rgb_enable_r;
    logic                         residual_error_r;

    logic                         act_mode_s;
    logic [1:0]                   eff_cnt_s;
    logic [NB-1:0][7:0]           bytes_s;
    logic [CW-1:0]                total_s;
    logic [CW-1:0]                bpp_s;
    logic [CW-1:0]                used_s;
    logic [1:0]                   rem_s;
    logic [OUT_PIXELS-1:0][23:0]  pix_s;
    logic [OUT_PIXELS-1:0]        pix_en_s;
    logic [1:0][7:0]              next_buf_s;

    function automatic logic [23:0] expand_565(input logic [7:0] lo, input logic [7:0] hi);
        logic [15:0] w;
        w = {hi, lo};
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    // Merge residual and new beat bytes, slice pixels in wire order, keep the leftover.
    always_comb begin
        act_mode_s = line_start ? mode : mode_r;
        eff_cnt_s  = line_start ? 2'd0 : res_cnt_r;
        bpp_s      = act_mode_s ? 5'd2 : 5'd3;
        total_s    = CW'(LANES) + {3'd0, eff_cnt_s};

        bytes_s = '0;
        case (eff_cnt_s)
            2'd0:    bytes_s[LANES-1:0] = image_data;
            2'd1:    bytes_s[LANES:0]   = {image_data, res_buf_r[0]};
            2'd2:    bytes_s[LANES+1:0] = {image_data, res_buf_r};
            default: bytes_s = '0;
        endcase

        pix_s    = '0;
        pix_en_s = '0;
        used_s   = '0;
        for (int k = 0; k < OUT_PIXELS; k++) begin
            if (used_s + bpp_s <= total_s) begin
                pix_en_s[k] = 1'b1;
                used_s      = used_s + bpp_s;
                if (act_mode_s) begin
                    pix_s[k] = expand_565(bytes_s[2*k], bytes_s[2*k+1]);
                end else begin
                    pix_s[k] = {bytes_s[3*k+2], bytes_s[3*k+1], bytes_s[3*k]};
                end
            end else begin
                pix_s[k] = 24'h000000;
            end
        end

        rem_s      = 2'(total_s - used_s);
        next_buf_s = '0;
        for (int j = 0; j < NB - 1; j++) begin
            next_buf_s = (CW'(j) == used_s) ? {bytes_s[j+1], bytes_s[j]} : next_buf_s;
        end
    end

    // State and registered outputs; line_start clears the residual even on idle cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_r           <= 1'b0;
            res_cnt_r        <= 2'd0;
            res_buf_r        <= '0;
            rgb_r            <= '0;
            rgb_enable_r     <= '0;
            residual_error_r <= 1'b0;
        end else begin
            residual_error_r <= line_start & (res_cnt_r != 2'd0);
            mode_r           <= act_mode_s;
            if (image_data_enable) begin
                res_cnt_r    <= rem_s;
                res_buf_r    <= next_buf_s;
                rgb_r        <= pix_s;
                rgb_enable_r <= pix_en_s;
            end else begin
                res_cnt_r    <= eff_cnt_s;
                rgb_r        <= '0;
                rgb_enable_r <= '0;
            end
        end
    end

    assign rgb            = rgb_r;
    assign rgb_enable     = rgb_enable_r;
    assign residual_error = residual_error_r;

endmodule

// File: tb/tb_csi_rgb_unpacker.sv
// Bench for csi_rgb_unpacker at LANES=1/4/8 against a byte-queue reference model.
module tb_csi_rgb_unpacker;

    logic clock;
    logic reset_n;
    logic mode;
    logic line_start;
    logic en1, en4, en8;
    logic [0:0][7:0]  d1;
    logic [3:0][7:0]  d4;
    logic [7:0][7:0]  d8;
    logic [0:0][23:0] rgb1;
    logic [1:0][23:0] rgb4;
    logic [3:0][23:0] rgb8;
    logic [0:0]       re1;
    logic [1:0]       re4;
    logic [3:0]       re8;
    logic             err1, err4, err8;

    int checks = 0;
    int passes = 0;

    // Reference model state: a plain byte FIFO and the active mode.
    logic [7:0]       bq[$];
    logic             mm;
    int               exp_n;
    logic [3:0][23:0] exp_rgb;
    logic             exp_err;

    logic [3:0]       obs_en;
    logic [3:0][23:0] obs_rgb;
    logic             obs_err;

    csi_rgb_unpacker #(.LANES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .mode(mode), .line_start(line_start),
        .image_data(d1), .image_data_enable(en1),
        .rgb(rgb1), .rgb_enable(re1), .residual_error(err1));

    csi_rgb_unpacker #(.LANES(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .mode(mode), .line_start(line_start),
        .image_data(d4), .image_data_enable(en4),
        .rgb(rgb4), .rgb_enable(re4), .residual_error(err4));

    csi_rgb_unpacker #(.LANES(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .mode(mode), .line_start(line_start),
        .image_data(d8), .image_data_enable(en8),
        .rgb(rgb8), .rgb_enable(re8), .residual_error(err8));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        bq.delete();
        mm = 1'b0;
    endtask

    task automatic model_beat(input logic ls, input logic en, input logic m,
                              input int n, input logic [63:0] data);
        logic [7:0] b0, b1, b2;
        logic [15:0] w;
        logic [4:0] r5, b5;
        logic [5:0] g6;
        int bpp;
        exp_n   = 0;
        exp_rgb = '0;
        exp_err = 1'b0;
        if (ls) begin
            exp_err = (bq.size() != 0);
            bq.delete();
            mm = m;
        end
        if (en) begin
            for (int i = 0; i < n; i++) bq.push_back(data[8*i +: 8]);
            bpp = mm ? 2 : 3;
            while (bq.size() >= bpp) begin
                b0 = bq.pop_front();
                b1 = bq.pop_front();
                if (mm) begin
                    w  = {b1, b0};
                    r5 = w[15:11];
                    g6 = w[10:5];
                    b5 = w[4:0];
                    exp_rgb[exp_n] = {8'((r5 << 3) | (r5 >> 2)),
                                      8'((g6 << 2) | (g6 >> 4)),
                                      8'((b5 << 3) | (b5 >> 2))};
                end else begin
                    b2 = bq.pop_front();
                    exp_rgb[exp_n] = {b2, b1, b0};
                end
                exp_n++;
            end
        end
    endtask

    task automatic step(input int lanes, input logic ls, input logic en, input logic m,
                        input logic [63:0] data, input string nm);
        logic [3:0] exp_en;
        @(negedge clock);
        line_start = ls;
        mode       = m;
        en1 = 1'b0; en4 = 1'b0; en8 = 1'b0;
        case (lanes)
            1:       begin en1 = en; d1 = data[7:0];  end
            4:       begin en4 = en; d4 = data[31:0]; end
            default: begin en8 = en; d8 = data;       end
        endcase
        model_beat(ls, en, m, lanes, data);
        @(posedge clock);
        #1;
        obs_rgb = '0;
        case (lanes)
            1:       begin obs_en = {3'b000, re1}; obs_rgb[0] = rgb1[0]; obs_err = err1; end
            4:       begin obs_en = {2'b00, re4}; obs_rgb[1:0] = rgb4; obs_err = err4; end
            default: begin obs_en = re8; obs_rgb = rgb8; obs_err = err8; end
        endcase
        exp_en = 4'((5'd1 << exp_n) - 5'd1);
        checks++;
        if (obs_en !== exp_en)
            $display("FAIL %s L%0d rgb_enable: got %b want %b", nm, lanes, obs_en, exp_en);
        else passes++;
        checks++;
        if (obs_rgb !== exp_rgb)
            $display("FAIL %s L%0d rgb: got %h want %h", nm, lanes, obs_rgb, exp_rgb);
        else passes++;
        checks++;
        if (obs_err !== exp_err)
            $display("FAIL %s L%0d residual_error: got %b want %b", nm, lanes, obs_err, exp_err);
        else passes++;
        line_start = 1'b0;
        en1 = 1'b0; en4 = 1'b0; en8 = 1'b0;
    endtask

    task automatic apply_reset(input string nm);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rgb1, rgb4, rgb8, re1, re4, re8, err1, err4, err8} !== '0)
            $display("FAIL %s outputs during reset: got %h want 0", nm,
                     {rgb1, rgb4, rgb8, re1, re4, re8, err1, err4, err8});
        else passes++;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic check_px(input string nm, input int slot, input logic [23:0] want);
        checks++;
        if (obs_rgb[slot] !== want)
            $display("FAIL %s slot%0d: got %h want %h", nm, slot, obs_rgb[slot], want);
        else passes++;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_rgb888_seq();
        step(4, 1'b1, 1'b1, 1'b0, 64'h03020100, "rgb888_b1");
        check_px("rgb888_b1", 0, 24'h020100);
        step(4, 1'b0, 1'b1, 1'b0, 64'h07060504, "rgb888_b2");
        check_px("rgb888_b2", 0, 24'h050403);
        step(4, 1'b0, 1'b1, 1'b0, 64'h0B0A0908, "rgb888_b3");
        check_px("rgb888_b3", 0, 24'h080706);
        check_px("rgb888_b3", 1, 24'h0B0A09);
    endtask

    task automatic test_rgb565();
        step(4, 1'b1, 1'b1, 1'b1, 64'h07E0F800, "rgb565_b1");
        check_px("rgb565_b1", 0, 24'hFF0000);
        check_px("rgb565_b1", 1, 24'h00FF00);
        step(4, 1'b0, 1'b1, 1'b1, 64'h8410001F, "rgb565_b2");
        check_px("rgb565_b2", 0, 24'h0000FF);
        check_px("rgb565_b2", 1, 24'h848284);
    endtask

    task automatic test_gaps();
        step(4, 1'b1, 1'b1, 1'b0, 64'h03020100, "gap_b1");
        check_px("gap_b1", 0, 24'h020100);
        for (int i = 0; i < 5; i++) step(4, 1'b0, 1'b0, 1'b0, 64'h0, "gap_idle1");
        step(4, 1'b0, 1'b1, 1'b0, 64'h07060504, "gap_b2");
        check_px("gap_b2", 0, 24'h050403);
        for (int i = 0; i < 5; i++) step(4, 1'b0, 1'b0, 1'b0, 64'h0, "gap_idle2");
        step(4, 1'b0, 1'b1, 1'b0, 64'h0B0A0908, "gap_b3");
        check_px("gap_b3", 0, 24'h080706);
        check_px("gap_b3", 1, 24'h0B0A09);
    endtask

    task automatic test_residual_error();
        step(4, 1'b1, 1'b1, 1'b0, 64'h03020100, "resid_b1");
        step(4, 1'b1, 1'b1, 1'b0, 64'h13121110, "resid_ls");
        check_px("resid_ls", 0, 24'h121110);
        checks++;
        if (obs_err !== 1'b1) $display("FAIL resid_ls pulse: got %b want 1", obs_err);
        else passes++;
        step(4, 1'b0, 1'b0, 1'b0, 64'h0, "resid_after");
    endtask

    task automatic test_mode_change();
        step(4, 1'b1, 1'b1, 1'b0, 64'h03020100, "mode_b1");
        step(4, 1'b0, 1'b1, 1'b1, 64'h07060504, "mode_ignored");
        check_px("mode_ignored", 0, 24'h050403);
        step(4, 1'b1, 1'b1, 1'b1, 64'h07E0F800, "mode_switch");
        check_px("mode_switch", 0, 24'hFF0000);
        check_px("mode_switch", 1, 24'h00FF00);
    endtask

    task automatic test_reset_midline();
        step(4, 1'b1, 1'b1, 1'b0, 64'h03020100, "rst_b1");
        step(4, 1'b0, 1'b1, 1'b0, 64'h07060504, "rst_b2");
        apply_reset("rst_midline");
        step(4, 1'b0, 1'b1, 1'b0, 64'h03020100, "rst_after");
        check_px("rst_after", 0, 24'h020100);
        step(4, 1'b1, 1'b1, 1'b1, 64'h07E0F800, "rst_565line");
        apply_reset("rst_565");
        step(4, 1'b0, 1'b1, 1'b1, 64'h03020100, "rst_default888");
        check_px("rst_default888", 0, 24'h020100);
    endtask

    task automatic test_random(input int lanes, input int n);
        for (int i = 0; i < n; i++) begin
            step(lanes, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, "random");
        end
    endtask

    initial begin
        reset_n    = 1'b1;
        mode       = 1'b0;
        line_start = 1'b0;
        en1 = 1'b0; en4 = 1'b0; en8 = 1'b0;
        d1 = '0; d4 = '0; d8 = '0;
        model_reset();
        test_reset();
        test_rgb888_seq();
        test_rgb565();
        test_gaps();
        test_residual_error();
        test_mode_change();
        test_reset_midline();
        test_random(4, 200);
        apply_reset("pre_l1");
        test_random(1, 200);
        apply_reset("pre_l8");
        test_random(8, 200);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
